// File: rtl/riscv_pipe_ctl_pkg.sv
// Shared RISC-V definitions: opcode/funct3 constants plus the pipeline-control
// state and halt-cause encodings.
package riscv_pipe_ctl_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
    localparam logic [2:0] FUNCT3_BNE  = 3'b001;
    localparam logic [2:0] FUNCT3_BLT  = 3'b100;
    localparam logic [2:0] FUNCT3_BGE  = 3'b101;
    localparam logic [2:0] FUNCT3_BLTU = 3'b110;
    localparam logic [2:0] FUNCT3_BGEU = 3'b111;
    localparam logic [2:0] FUNCT3_LB   = 3'b000;
    localparam logic [2:0] FUNCT3_LH   = 3'b001;
    localparam logic [2:0] FUNCT3_LW   = 3'b010;
    localparam logic [2:0] FUNCT3_LBU  = 3'b100;
    localparam logic [2:0] FUNCT3_LHU  = 3'b101;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_LOAD_WAIT = 2'd1,
        ST_FLUSH     = 2'd2,
        ST_HALT      = 2'd3
    } pipe_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_EXC     = 2'd1,
        CAUSE_TIMEOUT = 2'd2
    } halt_cause_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        return (val == 16'hFFFF) ? val : (val + 16'd1);
    endfunction

endpackage

// File: rtl/riscv_pipe_ctl_if.sv
// Handshake bundle between the pipeline datapath (master) and the
// pipeline controller (slave).
interface riscv_pipe_ctl_if;

    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic [4:0]  ex_rd;
    logic        ex_memfetch;
    logic        mem_ready;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        exception;

    logic        bubble;
    logic        id_flush;
    logic        pc_load;
    logic [31:0] pc_next;
    logic        halted;
    logic [1:0]  cause;
    logic [15:0] stall_count;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memfetch,
               mem_ready, branch_taken, branch_target, exception,
        input  bubble, id_flush, pc_load, pc_next, halted, cause, stall_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_memfetch,
               mem_ready, branch_taken, branch_target, exception,
        output bubble, id_flush, pc_load, pc_next, halted, cause, stall_count
    );

endinterface

// File: rtl/riscv_hazard_det.sv
// Load-use hazard comparator: flags an ID operand that depends on a load
// still in EX. Writes to x0 never create a dependency.
module riscv_hazard_det (
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_use_rs1_i,
    input  logic       id_use_rs2_i,
    input  logic [4:0] ex_rd_i,
    input  logic       ex_memfetch_i,
    output logic       hazard_o
);

    logic rs1_hit_s;
    logic rs2_hit_s;

    // Operand match against the load destination
    always_comb begin
        rs1_hit_s = id_use_rs1_i && (id_rs1_i == ex_rd_i);
        rs2_hit_s = id_use_rs2_i && (id_rs2_i == ex_rd_i);
        hazard_o  = ex_memfetch_i && (ex_rd_i != 5'd0) && (rs1_hit_s || rs2_hit_s);
    end

endmodule

// File: rtl/riscv_pipe_ctl.sv
// Pipeline control FSM: load-use stalls, taken-branch redirect/flush,
// exception and load-timeout halts, and a saturating stall counter.
module riscv_pipe_ctl
    import riscv_pipe_ctl_pkg::*;
#(
    parameter int MEM_TIMEOUT  = 15,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    riscv_pipe_ctl_if.slave  pif
);

    // The redirect cycle itself is the first squashed slot.
    localparam logic [15:0] FLUSH_LOAD  = (FLUSH_CYCLES > 1) ? 16'(FLUSH_CYCLES - 1) : 16'd0;
    localparam logic [15:0] TIMEOUT_CNT = 16'(MEM_TIMEOUT);
    localparam pipe_state_e REDIRECT_ST = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;

    pipe_state_e state_q, state_d;
    halt_cause_e cause_q, cause_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] stall_q, stall_d;
    logic [15:0] wait_inc_s;

    logic hazard_s;
    logic bubble_s, flush_s, pc_load_s;
    logic bubble_o_s, flush_o_s, pc_load_o_s, halted_o_s;

    riscv_hazard_det u_hazard (
        .id_rs1_i      (pif.id_rs1),
        .id_rs2_i      (pif.id_rs2),
        .id_use_rs1_i  (pif.id_use_rs1),
        .id_use_rs2_i  (pif.id_use_rs2),
        .ex_rd_i       (pif.ex_rd),
        .ex_memfetch_i (pif.ex_memfetch),
        .hazard_o      (hazard_s)
    );

    assign wait_inc_s = cnt_q + 16'd1;

    // Next-state and raw control decode
    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        cnt_d     = cnt_q;
        bubble_s  = 1'b0;
        flush_s   = 1'b0;
        pc_load_s = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (pif.exception) begin
                    bubble_s = 1'b1;
                    flush_s  = 1'b1;
                    cause_d  = CAUSE_EXC;
                    state_d  = ST_HALT;
                end else if (pif.branch_taken) begin
                    pc_load_s = 1'b1;
                    flush_s   = 1'b1;
                    cnt_d     = FLUSH_LOAD;
                    state_d   = REDIRECT_ST;
                end else if (hazard_s && !pif.mem_ready) begin
                    bubble_s = 1'b1;
                    flush_s  = 1'b1;
                    cnt_d    = 16'd0;
                    state_d  = ST_LOAD_WAIT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_LOAD_WAIT: begin
                bubble_s = 1'b1;
                flush_s  = 1'b1;
                if (pif.exception) begin
                    cause_d = CAUSE_EXC;
                    state_d = ST_HALT;
                end else if (pif.mem_ready) begin
                    bubble_s = 1'b0;
                    cnt_d    = 16'd0;
                    state_d  = ST_RUN;
                end else if (wait_inc_s >= TIMEOUT_CNT) begin
                    cause_d = CAUSE_TIMEOUT;
                    cnt_d   = 16'd0;
                    state_d = ST_HALT;
                end else begin
                    cnt_d = wait_inc_s;
                end
            end
            ST_FLUSH: begin
                // Exceptions here come from wrong-path slots and are dropped.
                flush_s = 1'b1;
                if (pif.branch_taken) begin
                    pc_load_s = 1'b1;
                    cnt_d     = FLUSH_LOAD;
                    state_d   = REDIRECT_ST;
                end else if (cnt_q <= 16'd1) begin
                    cnt_d   = 16'd0;
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_HALT: begin
                bubble_s = 1'b1;
                flush_s  = 1'b1;
            end
            default: begin
                cnt_d   = 16'd0;
                cause_d = CAUSE_NONE;
                state_d = ST_RUN;
            end
        endcase
    end

    // Output decode, overridden by the reset values while rst is low
    always_comb begin
        if (!rst) begin
            bubble_o_s  = 1'b0;
            flush_o_s   = 1'b1;
            pc_load_o_s = 1'b0;
            halted_o_s  = 1'b0;
        end else begin
            bubble_o_s  = bubble_s;
            flush_o_s   = flush_s;
            pc_load_o_s = pc_load_s;
            halted_o_s  = (state_q == ST_HALT);
        end
    end

    // Stall accounting excludes the halted state
    always_comb begin
        if (bubble_o_s && !halted_o_s) begin
            stall_d = sat_inc16(stall_q);
        end else begin
            stall_d = stall_q;
        end
    end

    // State, counter, cause and stall-count registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            cause_q <= CAUSE_NONE;
            cnt_q   <= 16'd0;
            stall_q <= 16'd0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    assign pif.bubble      = bubble_o_s;
    assign pif.id_flush    = flush_o_s;
    assign pif.pc_load     = pc_load_o_s;
    assign pif.pc_next     = pc_load_o_s ? pif.branch_target : 32'd0;
    assign pif.halted      = halted_o_s;
    assign pif.cause       = cause_q;
    assign pif.stall_count = stall_q;

endmodule

// File: tb/tb_riscv_pipe_ctl.sv
// Self-checking bench for riscv_pipe_ctl: vector table plus hand-built
// sequences, with expected outputs queued at drive time and checked at negedge.
module tb_riscv_pipe_ctl;

    typedef struct {
        string       name;
        logic        rst;
        logic        exc;
        logic        br;
        logic [31:0] tgt;
        logic        mf;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic        u1;
        logic [4:0]  rs2;
        logic        u2;
        logic        rdy;
        logic        e_bub;
        logic        e_fl;
        logic        e_pcl;
        logic [31:0] e_pcn;
        logic        e_halt;
        logic [1:0]  e_cause;
        logic [15:0] e_stall;
    } vec_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    vec_t tbl[$];
    vec_t sb[$];

    riscv_pipe_ctl_if pif ();

    riscv_pipe_ctl #(.MEM_TIMEOUT(15), .FLUSH_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .pif (pif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input string n, input logic r, input logic exc, input logic br,
                                input logic [31:0] tgt, input logic mf, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                                input logic u2, input logic rdy, input logic eb, input logic ef,
                                input logic ep, input logic [31:0] en, input logic eh,
                                input logic [1:0] ec, input logic [15:0] es);
        vec_t v;
        v.name = n; v.rst = r; v.exc = exc; v.br = br; v.tgt = tgt; v.mf = mf; v.rd = rd;
        v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2; v.rdy = rdy;
        v.e_bub = eb; v.e_fl = ef; v.e_pcl = ep; v.e_pcn = en; v.e_halt = eh;
        v.e_cause = ec; v.e_stall = es;
        return v;
    endfunction

    task automatic chk(input string vn, input string field, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s.%s: got %0h expected %0h", vn, field, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        @(posedge clk);
        #1;
        rst               = v.rst;
        pif.exception     = v.exc;
        pif.branch_taken  = v.br;
        pif.branch_target = v.tgt;
        pif.ex_memfetch   = v.mf;
        pif.ex_rd         = v.rd;
        pif.id_rs1        = v.rs1;
        pif.id_use_rs1    = v.u1;
        pif.id_rs2        = v.rs2;
        pif.id_use_rs2    = v.u2;
        pif.mem_ready     = v.rdy;
        sb.push_back(v);
    endtask

    // Scoreboard: compare the oldest queued expectation mid-cycle
    always @(negedge clk) begin : mon
        vec_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.name, "bubble",      32'(pif.bubble),      32'(e.e_bub));
            chk(e.name, "id_flush",    32'(pif.id_flush),    32'(e.e_fl));
            chk(e.name, "pc_load",     32'(pif.pc_load),     32'(e.e_pcl));
            chk(e.name, "pc_next",     pif.pc_next,          e.e_pcn);
            chk(e.name, "halted",      32'(pif.halted),      32'(e.e_halt));
            chk(e.name, "cause",       32'(pif.cause),       32'(e.e_cause));
            chk(e.name, "stall_count", 32'(pif.stall_count), 32'(e.e_stall));
        end
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        pif.exception = 1'b0; pif.branch_taken = 1'b0; pif.branch_target = 32'd0;
        pif.ex_memfetch = 1'b0; pif.ex_rd = 5'd0; pif.id_rs1 = 5'd0; pif.id_use_rs1 = 1'b0;
        pif.id_rs2 = 5'd0; pif.id_use_rs2 = 1'b0; pif.mem_ready = 1'b0;

        //              name            rst exc br tgt       mf rd    rs1   u1 rs2   u2 rdy | bub fl pcl pcn       hlt cause stall
        tbl.push_back(mk("rst_hold",     0, 0, 1, 32'h40,  1, 5'd5, 5'd5, 1, 5'd0, 0, 0,   0, 1, 0, 32'h0,   0, 2'd0, 16'd0));
        tbl.push_back(mk("rst_idle",     0, 0, 0, 32'h0,   0, 5'd0, 5'd0, 0, 5'd0, 0, 0,   0, 1, 0, 32'h0,   0, 2'd0, 16'd0));
        tbl.push_back(mk("idle",         1, 0, 0, 32'h0,   0, 5'd0, 5'd0, 0, 5'd0, 0, 0,   0, 0, 0, 32'h0,   0, 2'd0, 16'd0));
        tbl.push_back(mk("lu_stall1",    1, 0, 0, 32'h0,   1, 5'd5, 5'd5, 1, 5'd0, 0, 0,   1, 1, 0, 32'h0,   0, 2'd0, 16'd0));
        tbl.push_back(mk("lu_stall2",    1, 0, 0, 32'h0,   1, 5'd5, 5'd5, 1, 5'd0, 0, 0,   1, 1, 0, 32'h0,   0, 2'd0, 16'd1));
        tbl.push_back(mk("lu_stall3",    1, 0, 0, 32'h0,   1, 5'd5, 5'd5, 1, 5'd0, 0, 0,   1, 1, 0, 32'h0,   0, 2'd0, 16'd2));
        tbl.push_back(mk("lu_exit",      1, 0, 0, 32'h0,   1, 5'd5, 5'd5, 1, 5'd0, 0, 1,   0, 1, 0, 32'h0,   0, 2'd0, 16'd3));
        tbl.push_back(mk("lu_after",     1, 0, 0, 32'h0,   0, 5'd0, 5'd0, 0, 5'd0, 0, 0,   0, 0, 0, 32'h0,   0, 2'd0, 16'd3));
        tbl.push_back(mk("x0_load",      1, 0, 0, 32'h0,   1, 5'd0, 5'd0, 1, 5'd0, 0, 0,   0, 0, 0, 32'h0,   0, 2'd0, 16'd3));
        tbl.push_back(mk("hz_ready",     1, 0, 0, 32'h0,   1, 5'd5, 5'd5, 1, 5'd0, 0, 1,   0, 0, 0, 32'h0,   0, 2'd0, 16'd3));
        tbl.push_back(mk("no_use",       1, 0, 0, 32'h0,   1, 5'd5, 5'd5, 0, 5'd5, 0, 0,   0, 0, 0, 32'h0,   0, 2'd0, 16'd3));
        tbl.push_back(mk("not_load",     1, 0, 0, 32'h0,   0, 5'd5, 5'd5, 1, 5'd0, 0, 0,   0, 0, 0, 32'h0,   0, 2'd0, 16'd3));
        tbl.push_back(mk("rs2_hz",       1, 0, 0, 32'h0,   1, 5'd7, 5'd3, 1, 5'd7, 1, 0,   1, 1, 0, 32'h0,   0, 2'd0, 16'd3));
        tbl.push_back(mk("rs2_exit",     1, 0, 0, 32'h0,   1, 5'd7, 5'd3, 1, 5'd7, 1, 1,   0, 1, 0, 32'h0,   0, 2'd0, 16'd4));
        tbl.push_back(mk("br_40",        1, 0, 1, 32'h40,  0, 5'd0, 5'd0, 0, 5'd0, 0, 0,   0, 1, 1, 32'h40,  0, 2'd0, 16'd4));
        tbl.push_back(mk("br_tail",      1, 0, 0, 32'h40,  0, 5'd0, 5'd0, 0, 5'd0, 0, 0,   0, 1, 0, 32'h0,   0, 2'd0, 16'd4));
        tbl.push_back(mk("br_run",       1, 0, 0, 32'h0,   0, 5'd0, 5'd0, 0, 5'd0, 0, 0,   0, 0, 0, 32'h0,   0, 2'd0, 16'd4));
        tbl.push_back(mk("br_100",       1, 0, 1, 32'h100, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0,   0, 1, 1, 32'h100, 0, 2'd0, 16'd4));
        tbl.push_back(mk("fl_exc_ign",   1, 1, 0, 32'h0,   0, 5'd0, 5'd0, 0, 5'd0, 0, 0,   0, 1, 0, 32'h0,   0, 2'd0, 16'd4));
        tbl.push_back(mk("fl_exc_run",   1, 0, 0, 32'h0,   0, 5'd0, 5'd0, 0, 5'd0, 0, 0,   0, 0, 0, 32'h0,   0, 2'd0, 16'd4));
        tbl.push_back(mk("br_200",       1, 0, 1, 32'h200, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0,   0, 1, 1, 32'h200, 0, 2'd0, 16'd4));
        tbl.push_back(mk("fl_rebr_300",  1, 0, 1, 32'h300, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0,   0, 1, 1, 32'h300, 0, 2'd0, 16'd4));
        tbl.push_back(mk("fl_rebr_tail", 1, 0, 0, 32'h0,   0, 5'd0, 5'd0, 0, 5'd0, 0, 0,   0, 1, 0, 32'h0,   0, 2'd0, 16'd4));
        tbl.push_back(mk("br_over_hz",   1, 0, 1, 32'h80,  1, 5'd5, 5'd5, 1, 5'd0, 0, 0,   0, 1, 1, 32'h80,  0, 2'd0, 16'd4));
        tbl.push_back(mk("fl_hz_ign",    1, 0, 0, 32'h0,   1, 5'd5, 5'd5, 1, 5'd0, 0, 0,   0, 1, 0, 32'h0,   0, 2'd0, 16'd4));
        tbl.push_back(mk("lw_enter",     1, 0, 0, 32'h0,   1, 5'd5, 5'd5, 1, 5'd0, 0, 0,   1, 1, 0, 32'h0,   0, 2'd0, 16'd4));
        tbl.push_back(mk("lw_exc",       1, 1, 0, 32'h0,   1, 5'd5, 5'd5, 1, 5'd0, 0, 1,   1, 1, 0, 32'h0,   0, 2'd0, 16'd5));
        tbl.push_back(mk("halt_idle",    1, 0, 0, 32'h0,   0, 5'd0, 5'd0, 0, 5'd0, 0, 0,   1, 1, 0, 32'h0,   1, 2'd1, 16'd6));
        tbl.push_back(mk("halt_ign",     1, 1, 1, 32'h40,  0, 5'd0, 5'd0, 0, 5'd0, 0, 1,   1, 1, 0, 32'h0,   1, 2'd1, 16'd6));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
        end

        // Load timeout: one RUN cycle plus 15 LOAD_WAIT cycles, then halt
        drive(mk("tmo_rst", 0, 0, 0, 32'h0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 0, 32'h0, 0, 2'd0, 16'd0));
        for (int k = 0; k < 16; k++) begin
            drive(mk("tmo_wait", 1, 0, 0, 32'h0, 1, 5'd5, 5'd5, 1, 5'd0, 0, 0, 1, 1, 0, 32'h0, 0, 2'd0, 16'(k)));
        end
        drive(mk("tmo_halt",    1, 0, 0, 32'h0,  1, 5'd5, 5'd5, 1, 5'd0, 0, 0, 1, 1, 0, 32'h0, 1, 2'd2, 16'd16));
        drive(mk("tmo_exc_ign", 1, 1, 0, 32'h0,  1, 5'd5, 5'd5, 1, 5'd0, 0, 0, 1, 1, 0, 32'h0, 1, 2'd2, 16'd16));
        drive(mk("tmo_br_ign",  1, 0, 1, 32'h40, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1, 1, 0, 32'h0, 1, 2'd2, 16'd16));

        // Exception beats a simultaneous taken branch
        drive(mk("pri_rst",    0, 0, 0, 32'h0,  0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 0, 32'h0, 0, 2'd0, 16'd0));
        drive(mk("pri_exc_br", 1, 1, 1, 32'h44, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 1, 0, 32'h0, 0, 2'd0, 16'd0));
        drive(mk("pri_halt",   1, 0, 0, 32'h0,  0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 1, 0, 32'h0, 1, 2'd1, 16'd1));

        // Asynchronous reset in the middle of a load stall
        drive(mk("ms_rst",   0, 0, 0, 32'h0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 0, 32'h0, 0, 2'd0, 16'd0));
        drive(mk("ms_enter", 1, 0, 0, 32'h0, 1, 5'd5, 5'd5, 1, 5'd0, 0, 0, 1, 1, 0, 32'h0, 0, 2'd0, 16'd0));
        drive(mk("ms_lw",    1, 0, 0, 32'h0, 1, 5'd5, 5'd5, 1, 5'd0, 0, 0, 1, 1, 0, 32'h0, 0, 2'd0, 16'd1));
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("ms_async", "bubble",      32'(pif.bubble),      32'd0);
        chk("ms_async", "id_flush",    32'(pif.id_flush),    32'd1);
        chk("ms_async", "pc_load",     32'(pif.pc_load),     32'd0);
        chk("ms_async", "pc_next",     pif.pc_next,          32'd0);
        chk("ms_async", "halted",      32'(pif.halted),      32'd0);
        chk("ms_async", "cause",       32'(pif.cause),       32'd0);
        chk("ms_async", "stall_count", 32'(pif.stall_count), 32'd0);
        drive(mk("ms_run",      1, 0, 0, 32'h0,  0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, 32'h0,  0, 2'd0, 16'd0));
        drive(mk("ms_hz_ready", 1, 0, 0, 32'h0,  1, 5'd5, 5'd5, 1, 5'd0, 0, 1, 0, 0, 0, 32'h0,  0, 2'd0, 16'd0));
        drive(mk("ms_br",       1, 0, 1, 32'h40, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 1, 32'h40, 0, 2'd0, 16'd0));
        drive(mk("ms_br_tail",  1, 0, 0, 32'h0,  0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 1, 0, 32'h0,  0, 2'd0, 16'd0));

        for (int w = 0; w < 8 && sb.size() > 0; w++) begin
            @(posedge clk);
        end
        n_cmp = n_cmp + 1;
        if (sb.size() != 0) begin
            n_err = n_err + 1;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
